// File: rtl/adder4_bist_pkg.sv
// Shared types and helpers for the 4-bit adder self-test driver.
// The state encoding is fixed so that the state register has a known reset pattern.
package adder4_bist_pkg;

    localparam int ADDER_WIDTH = 4;
    localparam int VEC_W       = 2*ADDER_WIDTH+1;
    localparam int NUM_VEC     = 2**VEC_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Golden sum: carry-out in the top bit.
    function automatic logic [ADDER_WIDTH:0] exp_sum(input logic [ADDER_WIDTH-1:0] a,
                                                     input logic [ADDER_WIDTH-1:0] b,
                                                     input logic                   cin);
        return {1'b0, a} + {1'b0, b} + {{ADDER_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/adder4_bist_driver_if.sv
// Bundle between the self-test driver and the adder under test plus its result/status lines.
interface adder4_bist_driver_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 10
);
    logic                 start;
    logic [WIDTH-1:0]     sum;
    logic                 c_out;
    logic [WIDTH-1:0]     A_data;
    logic [WIDTH-1:0]     B_data;
    logic                 c_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_CNT_W-1:0] err_count;
    logic [2*WIDTH:0]     first_fail;

    modport master (
        input  start, sum, c_out,
        output A_data, B_data, c_in, busy, done, pass, err_count, first_fail
    );

    modport slave (
        output start, sum, c_out,
        input  A_data, B_data, c_in, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/adder4_bist_vec_gen.sv
// Exhaustive vector index counter; the index splits as {c_in, A, B} so B varies fastest.
module adder4_bist_vec_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic             last_o,
    output logic [2*WIDTH:0] vec_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             cin_o
);
    localparam int VW = 2*WIDTH+1;

    logic [VW-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (advance_i) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign last_o               = &idx_q;
    assign vec_o                = idx_q;
    assign {cin_o, a_o, b_o}    = idx_q;

endmodule

// File: rtl/adder4_bist_driver.sv
// Clocked exhaustive self-test for a 4-bit adder: apply vector, wait a settle window,
// compare against the golden sum, and accumulate a saturating error count.
module adder4_bist_driver
    import adder4_bist_pkg::*;
#(
    parameter int WIDTH         = ADDER_WIDTH,
    parameter int SETTLE_CYCLES = 10,
    parameter int ERR_CNT_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder4_bist_driver_if.master bus
);
    localparam int         VEC_BITS    = 2*WIDTH+1;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES-1);

    state_t               state_q, state_d;
    logic [7:0]           settle_q, settle_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic                 cin_q, cin_d;
    logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [VEC_BITS-1:0]  ff_q, ff_d;

    logic                 start_run, vec_advance, vec_last, vec_cin, mismatch;
    logic [VEC_BITS-1:0]  vec_idx;
    logic [WIDTH-1:0]     vec_a, vec_b;
    logic [WIDTH:0]       expected;

    assign start_run   = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign vec_advance = (state_q == CHECK) && !vec_last;

    adder4_bist_vec_gen #(.WIDTH(WIDTH)) u_vec_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (start_run),
        .advance_i (vec_advance),
        .last_o    (vec_last),
        .vec_o     (vec_idx),
        .a_o       (vec_a),
        .b_o       (vec_b),
        .cin_o     (vec_cin)
    );

    assign expected = exp_sum(a_q, b_q, cin_q);
    assign mismatch = (bus.sum != expected[WIDTH-1:0]) || (bus.c_out != expected[WIDTH]);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        ff_d     = ff_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = APPLY;
            end
            APPLY: begin
                a_d      = vec_a;
                b_d      = vec_b;
                cin_d    = vec_cin;
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = CHECK;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (!(&err_q)) err_d = err_q + 1'b1;
                    if (err_q == '0) ff_d = vec_idx;
                end
                // pass must reflect a mismatch on the very last vector too
                if (vec_last) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = APPLY;
                end
            end
            DONE: begin
                if (bus.start) state_d = APPLY;
            end
            default: state_d = IDLE;
        endcase
        if (start_run) begin
            err_d  = '0;
            ff_d   = '0;
            pass_d = 1'b0;
            done_d = 1'b0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ff_q     <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
        end
    end

    assign bus.A_data     = a_q;
    assign bus.B_data     = b_q;
    assign bus.c_in       = cin_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_adder4_bist_driver.sv
// Bench for the adder self-test driver: two instances (settle 10 / 10-bit count, settle 1 / 8-bit count)
// each facing a behavioural adder with selectable faults; results compared to a vector-level reference.
module tb_adder4_bist_driver;
    localparam int NV = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder4_bist_driver_if #(.WIDTH(4), .ERR_CNT_W(10)) bus_a ();
    adder4_bist_driver_if #(.WIDTH(4), .ERR_CNT_W(8))  bus_b ();

    adder4_bist_driver #(.WIDTH(4), .SETTLE_CYCLES(10), .ERR_CNT_W(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    adder4_bist_driver #(.WIDTH(4), .SETTLE_CYCLES(1), .ERR_CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    int checks = 0;
    int errors = 0;
    int mode_a = 0;
    int mode_b = 0;
    bit bad_vec [NV];

    // Adder seen by the driver: ideal sum with an optional planted fault
    function automatic logic [4:0] adder_model(input int mode, input logic [8:0] v);
        logic [4:0] r;
        r = 5'(int'(v[8]) + int'(v[7:4]) + int'(v[3:0]));
        case (mode)
            1: r[0] = 1'b0;
            2: r[4] = 1'b1;
            3: r[3:0] = ~r[3:0];
            4: if (bad_vec[v]) r[0] = ~r[0];
            default: ;
        endcase
        return r;
    endfunction

    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic sel_b   = 1'b0;
    assign bus_a.start = start_a;
    assign bus_b.start = start_b;
    assign {bus_a.c_out, bus_a.sum} = adder_model(mode_a, {bus_a.c_in, bus_a.A_data, bus_a.B_data});
    assign {bus_b.c_out, bus_b.sum} = adder_model(mode_b, {bus_b.c_in, bus_b.A_data, bus_b.B_data});

    wire       done_s = sel_b ? bus_b.done : bus_a.done;
    wire       busy_s = sel_b ? bus_b.busy : bus_a.busy;
    wire       pass_s = sel_b ? bus_b.pass : bus_a.pass;
    wire [8:0] vec_s  = sel_b ? {bus_b.c_in, bus_b.A_data, bus_b.B_data}
                              : {bus_a.c_in, bus_a.A_data, bus_a.B_data};
    wire [9:0] err_s  = sel_b ? {2'b00, bus_b.err_count} : bus_a.err_count;
    wire [8:0] ff_s   = sel_b ? bus_b.first_fail : bus_a.first_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: walk every vector, count those where the adder differs from a+b+cin
    task automatic ref_run(input int mode, input int err_max, output int exp_err, output int exp_ff);
        int n;
        n = 0;
        exp_ff = 0;
        for (int v = 0; v < NV; v++) begin
            int ideal;
            ideal = (v >> 8) + ((v >> 4) & 15) + (v & 15);
            if (int'(adder_model(mode, 9'(v))) != ideal) begin
                if (n == 0) exp_ff = v;
                n++;
            end
        end
        exp_err = (n > err_max) ? err_max : n;
    endtask

    task automatic set_start(input bit v);
        if (sel_b) start_b = v; else start_a = v;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " vec"},  32'(vec_s),  0);
        check({tag, " busy"}, 32'(busy_s), 0);
        check({tag, " done"}, 32'(done_s), 0);
        check({tag, " pass"}, 32'(pass_s), 0);
        check({tag, " err"},  32'(err_s),  0);
        check({tag, " ff"},   32'(ff_s),   0);
    endtask

    // Pulse start, then count cycles until done; p1/p2 are extra start pulses mid-run
    task automatic run_to_done(input string tag, input int period, input int p1, input int p2);
        int cycles, probe_k, probe_c;
        probe_k = $urandom_range(0, NV-1);
        probe_c = probe_k*period + 1 + $urandom_range(0, period-1);
        @(negedge clk); set_start(1'b1);
        @(negedge clk); set_start(1'b0);
        check({tag, " clr_err"},  32'(err_s),  0);
        check({tag, " clr_done"}, 32'(done_s), 0);
        check({tag, " clr_pass"}, 32'(pass_s), 0);
        check({tag, " busy"},     32'(busy_s), 1);
        cycles = 0;
        while (cycles < 20000) begin
            @(negedge clk);
            cycles++;
            set_start(cycles == p1 || cycles == p2);
            if (cycles == probe_c) check({tag, " probe_vec"}, 32'(vec_s), 32'(probe_k));
            if (done_s) break;
        end
        set_start(1'b0);
        check({tag, " cycles"}, 32'(cycles), 32'(NV*period));
    endtask

    task automatic check_end(input string tag, input int exp_err, input int exp_ff);
        check({tag, " done"}, 32'(done_s), 1);
        check({tag, " busy"}, 32'(busy_s), 0);
        check({tag, " err"},  32'(err_s),  32'(exp_err));
        check({tag, " pass"}, 32'(pass_s), 32'(exp_err == 0));
        check({tag, " last_vec"}, 32'(vec_s), 511);
        if (exp_err != 0) check({tag, " ff"}, 32'(ff_s), 32'(exp_ff));
    endtask

    initial begin
        int ee, ef, dens;
        foreach (bad_vec[i]) bad_vec[i] = 1'b0;

        // Reset wins over start
        repeat (3) @(negedge clk);
        start_a = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        sel_b = 1'b0; check_zero("reset_a");
        sel_b = 1'b1; check_zero("reset_b");
        sel_b = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal adder, full run
        mode_a = 0;
        run_to_done("ideal", 12, -1, -1);
        check_end("ideal", 0, 0);

        // sum[0] stuck-at-0
        mode_a = 1;
        ref_run(1, 1023, ee, ef);
        run_to_done("sum0_sa0", 12, -1, -1);
        check_end("sum0_sa0", 256, 1);
        check("sum0_sa0 ref_err", 32'(err_s), 32'(ee));

        // Restart from DONE with c_out stuck-at-1; run_to_done checks the clearing edge
        mode_a = 2;
        ref_run(2, 1023, ee, ef);
        run_to_done("cout_sa1", 12, -1, -1);
        check_end("cout_sa1", 256, 0);
        check("cout_sa1 ref_err", 32'(err_s), 32'(ee));

        // start while busy is ignored; sum inverted with 10-bit counter
        mode_a = 3;
        run_to_done("busy_start", 12, 50, 3000);
        check_end("busy_start", 512, 0);

        // 8-bit counter saturates; settle window of one cycle
        sel_b = 1'b1;
        mode_b = 3;
        ref_run(3, 255, ee, ef);
        run_to_done("sat8", 3, -1, -1);
        check_end("sat8", 255, 0);
        check("sat8 ref_err", 32'(err_s), 32'(ee));

        // Random fault sets against the reference
        for (int it = 0; it < 3; it++) begin
            dens = $urandom_range(2, 90);
            foreach (bad_vec[i]) bad_vec[i] = ($urandom_range(0, 99) < dens);
            mode_b = 4;
            ref_run(4, 255, ee, ef);
            run_to_done("rand_b", 3, -1, -1);
            check_end("rand_b", ee, ef);
        end
        sel_b = 1'b0;
        dens = $urandom_range(2, 60);
        foreach (bad_vec[i]) bad_vec[i] = ($urandom_range(0, 99) < dens);
        mode_a = 4;
        ref_run(4, 1023, ee, ef);
        run_to_done("rand_a", 12, -1, -1);
        check_end("rand_a", ee, ef);

        // Reset mid-run at vector 100 aborts everything
        mode_a = 1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (100*12 + 4) @(negedge clk);
        check("midrst busy_before", 32'(busy_s), 1);
        check("midrst vec_before", 32'(vec_s), 100);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        rst_n = 1'b1;
        mode_a = 0;
        run_to_done("after_rst", 12, -1, -1);
        check_end("after_rst", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
